// File: rtl/exp_shift_cfg_sequencer.sv
// Run-time configuration sequencer for the exponent shifter and averaging CIC.
// Accepts {avg_len, fft_size} words and validates them. Each accepted word is
// applied on a clean frame boundary: the input gate closes after the current
// frame, the shifter pipeline/FIFO drains, the new settings load, the filter
// is reset, and the gate reopens. Output frames are counted until the average
// has settled at the new settings.
module exp_shift_cfg_sequencer #(
    parameter logic [11:0] DEF_FFT_SIZE = 12'd2048,
    parameter logic [8:0]  DEF_AVG_LEN  = 9'd256,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned SETTLE_EXTRA = 2
) (
    input  logic        clk,
    input  logic        sync_reset_n,
    input  logic        cfg_tvalid,
    input  logic [20:0] cfg_tdata,
    output logic        cfg_tready,
    input  logic        src_tvalid,
    input  logic        src_tlast,
    output logic        src_tready,
    output logic        shf_tvalid,
    input  logic        shf_tready,
    input  logic        shf_m_tvalid,
    input  logic        shf_m_tready,
    input  logic        shf_m_tlast,
    output logic [11:0] fft_size,
    output logic [8:0]  avg_len,
    output logic        filt_reset,
    output logic        busy,
    output logic        settled,
    output logic        cfg_err
);

    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
    localparam int unsigned FCW = 10;
    localparam logic [RCW-1:0]       RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [RCW-1:0]       RST_ONE  = RCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [FCW-1:0]       FRM_ONE  = FCW'(1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_EOF,
        ST_DRAIN,
        ST_APPLY,
        ST_RST_HOLD,
        ST_SETTLE
    } state_t;

    state_t               state;
    logic                 gate_open;
    logic [CNT_WIDTH-1:0] in_flight;
    logic                 frame_active;
    logic [11:0]          pend_fft;
    logic [8:0]           pend_avg;
    logic [RCW-1:0]       rst_cnt;
    logic [FCW-1:0]       frame_cnt;

    logic                 in_beat;
    logic                 out_beat;
    logic                 cfg_accept;
    logic [11:0]          cfg_fft;
    logic [8:0]           cfg_avg;
    logic                 cfg_ok;
    logic                 frame_next;
    logic [FCW-1:0]       frame_cnt_next;
    logic [FCW-1:0]       settle_target;

    // Only valid/ready pass through the gate; data/user bypass this block.
    assign shf_tvalid = src_tvalid & gate_open;
    assign src_tready = shf_tready & gate_open;
    assign cfg_tready = (state == ST_RUN);
    assign busy       = (state != ST_RUN);

    assign in_beat    = src_tvalid & src_tready;
    assign out_beat   = shf_m_tvalid & shf_m_tready;
    assign cfg_accept = cfg_tvalid & cfg_tready;

    assign cfg_fft = cfg_tdata[11:0];
    assign cfg_avg = cfg_tdata[20:12];

    // Decode the incoming word: power-of-two FFT 8..2048, averaging length 1..256.
    always_comb begin
        cfg_ok = 1'b0;
        if ((cfg_fft >= 12'd8) && (cfg_fft <= 12'd2048) &&
            ((cfg_fft & (cfg_fft - 12'd1)) == 12'd0) &&
            (cfg_avg != 9'd0) && (cfg_avg <= 9'd256)) begin
            cfg_ok = 1'b1;
        end
    end

    assign frame_next     = in_beat ? ~src_tlast : frame_active;
    assign frame_cnt_next = frame_cnt + FRM_ONE;
    assign settle_target  = {1'b0, avg_len} + FCW'(SETTLE_EXTRA);

    // Samples accepted by the shifter but not yet emitted; saturates both ways.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            in_flight <= '0;
        end else if (in_beat && !out_beat && (in_flight != '1)) begin
            in_flight <= in_flight + CNT_ONE;
        end else if (!in_beat && out_beat && (in_flight != '0)) begin
            in_flight <= in_flight - CNT_ONE;
        end
    end

    // Tracks whether an input frame has started but not yet seen its tlast.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            frame_active <= 1'b0;
        end else begin
            frame_active <= frame_next;
        end
    end

    // Reconfiguration sequence: wait for end of frame, drain, apply, reset, settle.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state      <= ST_SETTLE;
            gate_open  <= 1'b1;
            fft_size   <= DEF_FFT_SIZE;
            avg_len    <= DEF_AVG_LEN;
            pend_fft   <= DEF_FFT_SIZE;
            pend_avg   <= DEF_AVG_LEN;
            filt_reset <= 1'b0;
            settled    <= 1'b0;
            cfg_err    <= 1'b0;
            rst_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cfg_accept) begin
                        if (cfg_ok) begin
                            pend_fft <= cfg_fft;
                            pend_avg <= cfg_avg;
                            state    <= ST_WAIT_EOF;
                            // When no frame is open after this cycle the gate
                            // shuts now, so WAIT_EOF cannot admit a new frame.
                            gate_open <= frame_next;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_EOF: begin
                    if (!frame_active || (in_beat && src_tlast)) begin
                        gate_open <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (in_flight == '0) begin
                        settled <= 1'b0;
                        state   <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    fft_size   <= pend_fft;
                    avg_len    <= pend_avg;
                    filt_reset <= 1'b1;
                    settled    <= 1'b0;
                    rst_cnt    <= RST_LOAD;
                    state      <= ST_RST_HOLD;
                end
                ST_RST_HOLD: begin
                    if (rst_cnt == '0) begin
                        filt_reset <= 1'b0;
                        gate_open  <= 1'b1;
                        settled    <= 1'b0;
                        frame_cnt  <= '0;
                        state      <= ST_SETTLE;
                    end else begin
                        rst_cnt <= rst_cnt - RST_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (out_beat && shf_m_tlast) begin
                        if (frame_cnt_next == settle_target) begin
                            settled <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            frame_cnt <= frame_cnt_next;
                        end
                    end
                end
                default: begin
                    state <= ST_SETTLE;
                end
            endcase
        end
    end

endmodule

// File: doc/exp_shift_cfg_sequencer.md
Name: exp_shift_cfg_sequencer

Overview:
- Run-time configuration sequencer for the exponent shifter and its averaging CIC.
- Accepts new {avg_len, fft_size} words and validates them. It applies each accepted word only on a clean frame boundary:
  - finishes the current input frame, then closes the input gate;
  - drains the shifter pipeline/FIFO and applies the new settings;
  - pulses a filter reset, then reopens the gate.
- Sits between the FFT output stream and the shifter input. Only valid/ready is gated; tdata/tuser are wired around the block.
- Tracks averaging settle time and reports it on `settled`.

Parameters:
- DEF_FFT_SIZE, 12'd2048, fft_size driven after reset.
- DEF_AVG_LEN, 9'd256, avg_len driven after reset.
- CNT_WIDTH, 8, width of the in-flight sample counter. Must cover shifter pipeline (25) plus FIFO depth (64).
- RST_CYCLES, 4, cycles that filt_reset is held high after an apply.
- SETTLE_EXTRA, 2, extra output frames added to avg_len before `settled` asserts.

Ports:
- clk  in  1  system clock.
- sync_reset_n  in  1  synchronous, active-low reset.
- cfg_tvalid  in  1  config word valid.
- cfg_tdata  in  21  {avg_len[20:12], fft_size[11:0]}.
- cfg_tready  out  1  config accepted; high only in RUN.
- src_tvalid  in  1  upstream (FFT) sample valid.
- src_tlast  in  1  upstream end-of-frame.
- src_tready  out  1  ready to upstream.
- shf_tvalid  out  1  valid to shifter s_axis.
- shf_tready  in  1  shifter s_axis_tready.
- shf_m_tvalid  in  1  shifter m_axis_tvalid (monitor).
- shf_m_tready  in  1  shifter m_axis_tready (monitor).
- shf_m_tlast  in  1  shifter m_axis_tlast (monitor).
- fft_size  out  12  active FFT size.
- avg_len  out  9  active averaging length.
- filt_reset  out  1  active-high reset for shifter/CIC.
- busy  out  1  high in any state other than RUN.
- settled  out  1  average is valid at the current settings.
- cfg_err  out  1  one-cycle pulse when a config word is rejected.

Behaviour:
- Gating:
  - shf_tvalid = src_tvalid & gate_open; src_tready = shf_tready & gate_open.
  - gate_open is a register; in = src_tvalid & src_tready; out = shf_m_tvalid & shf_m_tready.
- in_flight counter:
  - +1 on in only; -1 on out only; unchanged on both or neither.
  - Saturates at 0 and at all-ones; it never wraps.
- frame_active: set on in with !src_tlast; cleared on in with src_tlast; 0 after reset.
- Reset (sync_reset_n low at a clk edge) — all state restored at the next edge, including mid-drain or mid-apply:
  - fft_size = DEF_FFT_SIZE, avg_len = DEF_AVG_LEN;
  - gate_open = 1, in_flight = 0, frame_active = 0;
  - settled = 0, cfg_err = 0, filt_reset = 0;
  - state = SETTLE with settle target DEF_AVG_LEN + SETTLE_EXTRA, busy = 1, cfg_tready = 0.
- Validation (on cfg_tvalid & cfg_tready) — the word is valid if both hold:
  - fft_size is a power of two in 8..2048;
  - avg_len is in 1..256.
  - Invalid: cfg_err = 1 on the next cycle, word dropped, stay in RUN.
  - Valid: latch it as pending and go to WAIT_EOF.
- States:
  - RUN: gate open, cfg_tready = 1, busy = 0.
  - WAIT_EOF: gate open, cfg_tready = 0.
    - On in & src_tlast: gate_open <= 0 and go to DRAIN. No beat after tlast reaches the shifter.
    - If frame_active = 0 on entry, close the gate immediately and go to DRAIN.
  - DRAIN: gate closed; wait for in_flight == 0, then go to APPLY.
  - APPLY (1 cycle): fft_size/avg_len <= pending; filt_reset <= 1; load a RST_CYCLES down-counter; go to RST_HOLD.
  - RST_HOLD: filt_reset stays high for exactly RST_CYCLES cycles total. Then filt_reset <= 0, gate_open <= 1, settled <= 0; go to SETTLE.
  - SETTLE: count output frames (out & shf_m_tlast). At count == avg_len + SETTLE_EXTRA: settled <= 1, go to RUN.
- settled clears on entry to APPLY.
- Outputs fft_size/avg_len change only in APPLY, never mid-frame.
- cfg_tvalid held outside RUN: not accepted; the word waits (cfg_tready = 0).
- in & src_tlast on the same cycle as a cfg accept in RUN: that boundary does not count. WAIT_EOF then sees frame_active = 0 and drains immediately.

Test Plan:
- Reset then 258 frames of fft_size 2048 -> fft_size = 2048, avg_len = 256, busy = 1; settled rises 1 cycle after the 258th output tlast; cfg_tready then 1.
- cfg {avg_len = 16, fft_size = 512} mid-frame at beat 100 of 2048 -> the remaining 1948 beats pass. The gate closes the cycle after tlast; APPLY fires when in_flight reaches 0. filt_reset is high for 4 cycles; fft_size = 512 and avg_len = 16 after APPLY; settled after 18 output frames.
- cfg with fft_size = 12'd1000 or avg_len = 0 or avg_len = 300 -> cfg_err 1-cycle pulse; outputs and state unchanged.
- Downstream m_axis_tready held low during DRAIN for 200 cycles -> stays in DRAIN (in_flight > 0), src_tready = 0 throughout; APPLY follows the final output beat.
- Config at idle (frame_active = 0, in_flight = 0) -> WAIT_EOF, DRAIN, APPLY on consecutive cycles.
- sync_reset_n low during RST_HOLD -> next cycle filt_reset = 0, fft_size = 2048, gate open, state SETTLE.
